// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator with a fixed-latency
// pixel return path and registered sync/DE/colour outputs.
//
// Ports:
//   clk, rst_n            pixel clock, async active-low reset
//   draw_r/g/b            colour for the coordinate issued DRAW_LAT
//                         clocks earlier
//   test_en               colour-bar select (VGA_TIMING_TEST_PATTERN_EN)
//   curr_x, curr_y        requested pixel, zero outside visible area
//   req_valid             curr_x/curr_y are in the visible area
//   pix_r/g/b, de         registered colour and data enable
//   hsync, vsync          syncs aligned with pix_*
//   line_start            pulse on first visible pixel of a line
//   frame_start           pulse on pixel (0,0)
//   frame_cnt             frame counter, steps with frame_start
//
// Optional feature macro: VGA_TIMING_TEST_PATTERN_EN adds test_en and
// an 8-bar colour pattern (H_ACTIVE must be a multiple of 8).
module vga_timing_gen #(
    parameter int H_ACTIVE   = 1280,
    parameter int H_FP       = 64,
    parameter int H_SYNC     = 136,
    parameter int H_BP       = 200,
    parameter int V_ACTIVE   = 800,
    parameter int V_FP       = 105,
    parameter int V_SYNC     = 3,
    parameter int V_BP       = 24,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 1,
    parameter int DRAW_LAT   = 2,
    parameter int COLOR_W    = 4,
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP,
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP,
    localparam int X_W     = $clog2(H_TOTAL),
    localparam int Y_W     = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COLOR_W-1:0] draw_r,
    input  logic [COLOR_W-1:0] draw_g,
    input  logic [COLOR_W-1:0] draw_b,
`ifdef VGA_TIMING_TEST_PATTERN_EN
    input  logic               test_en,
`endif
    output logic [X_W-1:0]     curr_x,
    output logic [Y_W-1:0]     curr_y,
    output logic               req_valid,
    output logic [COLOR_W-1:0] pix_r,
    output logic [COLOR_W-1:0] pix_g,
    output logic [COLOR_W-1:0] pix_b,
    output logic               de,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic [7:0]         frame_cnt
);

    localparam int H_ACT_S = H_SYNC + H_BP;
    localparam int H_ACT_E = H_ACT_S + H_ACTIVE;
    localparam int V_ACT_S = V_SYNC + V_BP;
    localparam int V_ACT_E = V_ACT_S + V_ACTIVE;

    localparam logic HS_ON = 1'(H_SYNC_POL);
    localparam logic VS_ON = 1'(V_SYNC_POL);

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
`endif

    // Syncs travel as active-high "asserted" flags so that every
    // delay-line stage resets to all zeros; polarity is applied only
    // at the output register.
    typedef struct packed {
`ifdef VGA_TIMING_TEST_PATTERN_EN
        logic [X_W-1:0] x;
`endif
        logic fs;
        logic ls;
        logic vs;
        logic hs;
        logic vld;
    } tap_t;

    // ------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------
    logic [X_W-1:0] hcnt_q, hcnt_d;
    logic [Y_W-1:0] vcnt_q, vcnt_d;

    always_comb begin
        hcnt_d = hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        if (hcnt_q == X_W'(H_TOTAL - 1)) begin
            hcnt_d = '0;
            if (vcnt_q == Y_W'(V_TOTAL - 1)) begin
                vcnt_d = '0;
            end else begin
                vcnt_d = vcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // ------------------------------------------------------------
    // Segment decode
    // ------------------------------------------------------------
    logic h_act;
    logic v_act;
    logic h_sync_act;
    logic v_sync_act;

    assign h_act = (32'(hcnt_q) >= H_ACT_S)
                && (32'(hcnt_q) <  H_ACT_E);
    assign v_act = (32'(vcnt_q) >= V_ACT_S)
                && (32'(vcnt_q) <  V_ACT_E);
    assign h_sync_act = 32'(hcnt_q) < H_SYNC;
    assign v_sync_act = 32'(vcnt_q) < V_SYNC;

    // ------------------------------------------------------------
    // Request stage
    // ------------------------------------------------------------
    tap_t           req_q, req_d;
    logic [X_W-1:0] curr_x_q, curr_x_d;
    logic [Y_W-1:0] curr_y_q, curr_y_d;

    always_comb begin
        req_d    = '0;
        curr_x_d = '0;
        curr_y_d = '0;
        req_d.vld = h_act && v_act;
        req_d.hs  = h_sync_act;
        req_d.vs  = v_sync_act;
        req_d.ls  = req_d.vld && (32'(hcnt_q) == H_ACT_S);
        req_d.fs  = req_d.ls && (32'(vcnt_q) == V_ACT_S);
        if (req_d.vld) begin
            curr_x_d = hcnt_q - X_W'(H_ACT_S);
            curr_y_d = vcnt_q - Y_W'(V_ACT_S);
        end
`ifdef VGA_TIMING_TEST_PATTERN_EN
        req_d.x = curr_x_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q    <= '0;
            curr_x_q <= '0;
            curr_y_q <= '0;
        end else begin
            req_q    <= req_d;
            curr_x_q <= curr_x_d;
            curr_y_q <= curr_y_d;
        end
    end

    assign curr_x    = curr_x_q;
    assign curr_y    = curr_y_q;
    assign req_valid = req_q.vld;

    // ------------------------------------------------------------
    // Delay line matching the renderer latency
    // ------------------------------------------------------------
    tap_t dly;

    generate
        if (DRAW_LAT == 0) begin : g_nodly
            // Draw data is combinational on the request outputs.
            assign dly = req_q;
        end else begin : g_dly
            tap_t sr_q [DRAW_LAT];
            tap_t sr_d [DRAW_LAT];

            always_comb begin
                sr_d[0] = req_q;
                for (int i = 1; i < DRAW_LAT; i++) begin
                    sr_d[i] = sr_q[i-1];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DRAW_LAT; i++) begin
                        sr_q[i] <= '0;
                    end
                end else begin
                    sr_q <= sr_d;
                end
            end

            assign dly = sr_q[DRAW_LAT-1];
        end
    endgenerate

    // ------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------
`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic [2:0] bar;
    assign bar = 3'(dly.x / X_W'(BAR_W));
`endif

    logic [COLOR_W-1:0] pix_r_q, pix_r_d;
    logic [COLOR_W-1:0] pix_g_q, pix_g_d;
    logic [COLOR_W-1:0] pix_b_q, pix_b_d;
    logic               de_q, de_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;

    always_comb begin
        pix_r_d = '0;
        pix_g_d = '0;
        pix_b_d = '0;
        if (dly.vld) begin
            pix_r_d = draw_r;
            pix_g_d = draw_g;
            pix_b_d = draw_b;
`ifdef VGA_TIMING_TEST_PATTERN_EN
            if (test_en) begin
                pix_r_d = {COLOR_W{bar[0]}};
                pix_g_d = {COLOR_W{bar[1]}};
                pix_b_d = {COLOR_W{bar[2]}};
            end
`endif
        end
        de_d          = dly.vld;
        hsync_d       = dly.hs ? HS_ON : ~HS_ON;
        vsync_d       = dly.vs ? VS_ON : ~VS_ON;
        line_start_d  = dly.ls;
        frame_start_d = dly.fs;
        frame_cnt_d   = frame_cnt_q;
        if (dly.fs) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_r_q       <= '0;
            pix_g_q       <= '0;
            pix_b_q       <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~HS_ON;
            vsync_q       <= ~VS_ON;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            pix_r_q       <= pix_r_d;
            pix_g_q       <= pix_g_d;
            pix_b_q       <= pix_b_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign pix_r       = pix_r_q;
    assign pix_g       = pix_g_q;
    assign pix_b       = pix_b_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen in the default
// mode and a small mode with DRAW_LAT of 2 and 0.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------
    // Default-mode instance
    // ------------------------------------------------------------
    logic        d0_rst_n;
    logic [10:0] d0_x;
    logic [9:0]  d0_y;
    logic        d0_rv, d0_de, d0_hs, d0_vs, d0_ls, d0_fs;
    logic [3:0]  d0_r, d0_g, d0_b;
    logic [7:0]  d0_fc;

    vga_timing_gen u_d0 (
        .clk(clk), .rst_n(d0_rst_n),
        .draw_r(4'h5), .draw_g(4'hA), .draw_b(4'h3),
`ifdef VGA_TIMING_TEST_PATTERN_EN
        .test_en(1'b0),
`endif
        .curr_x(d0_x), .curr_y(d0_y), .req_valid(d0_rv),
        .pix_r(d0_r), .pix_g(d0_g), .pix_b(d0_b),
        .de(d0_de), .hsync(d0_hs), .vsync(d0_vs),
        .line_start(d0_ls), .frame_start(d0_fs),
        .frame_cnt(d0_fc)
    );

    // ------------------------------------------------------------
    // Small-mode instances
    // ------------------------------------------------------------
    logic       s2_rst_n, s0_rst_n;
    logic [3:0] s2_x, s0_x;
    logic [2:0] s2_y, s0_y;
    logic       s2_rv, s2_de, s2_hs, s2_vs, s2_ls, s2_fs;
    logic       s0_rv, s0_de, s0_hs, s0_vs, s0_ls, s0_fs;
    logic [3:0] s2_r, s2_g, s2_b, s0_r, s0_g, s0_b;
    logic [3:0] s2_dr, s2_dg, s0_dr, s0_dg;
    logic [7:0] s2_fc, s0_fc;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .DRAW_LAT(2)
    ) u_s2 (
        .clk(clk), .rst_n(s2_rst_n),
        .draw_r(s2_dr), .draw_g(s2_dg), .draw_b(4'hC),
`ifdef VGA_TIMING_TEST_PATTERN_EN
        .test_en(1'b0),
`endif
        .curr_x(s2_x), .curr_y(s2_y), .req_valid(s2_rv),
        .pix_r(s2_r), .pix_g(s2_g), .pix_b(s2_b),
        .de(s2_de), .hsync(s2_hs), .vsync(s2_vs),
        .line_start(s2_ls), .frame_start(s2_fs),
        .frame_cnt(s2_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .DRAW_LAT(0)
    ) u_s0 (
        .clk(clk), .rst_n(s0_rst_n),
        .draw_r(s0_dr), .draw_g(s0_dg), .draw_b(4'hC),
`ifdef VGA_TIMING_TEST_PATTERN_EN
        .test_en(1'b0),
`endif
        .curr_x(s0_x), .curr_y(s0_y), .req_valid(s0_rv),
        .pix_r(s0_r), .pix_g(s0_g), .pix_b(s0_b),
        .de(s0_de), .hsync(s0_hs), .vsync(s0_vs),
        .line_start(s0_ls), .frame_start(s0_fs),
        .frame_cnt(s0_fc)
    );

`ifdef VGA_TIMING_TEST_PATTERN_EN
    logic       tp_rst_n;
    logic [3:0] tp_x;
    logic [2:0] tp_y;
    logic       tp_rv, tp_de, tp_hs, tp_vs, tp_ls, tp_fs;
    logic [3:0] tp_r, tp_g, tp_b;
    logic [7:0] tp_fc;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .DRAW_LAT(2)
    ) u_tp (
        .clk(clk), .rst_n(tp_rst_n),
        .draw_r(4'h7), .draw_g(4'h7), .draw_b(4'h7),
        .test_en(1'b1),
        .curr_x(tp_x), .curr_y(tp_y), .req_valid(tp_rv),
        .pix_r(tp_r), .pix_g(tp_g), .pix_b(tp_b),
        .de(tp_de), .hsync(tp_hs), .vsync(tp_vs),
        .line_start(tp_ls), .frame_start(tp_fs),
        .frame_cnt(tp_fc)
    );
`endif

    // ------------------------------------------------------------
    // Small-mode reference model (H_TOTAL=14, V_TOTAL=7)
    // ------------------------------------------------------------
    typedef struct packed {
        logic       v;
        logic [3:0] x;
        logic [2:0] y;
        logic       hs;
        logic       vs;
    } ent_t;

    function automatic ent_t model(input int h, input int v);
        ent_t e;
        e    = '0;
        e.hs = (h < 2);
        e.vs = (v < 1);
        e.v  = (h >= 4) && (h < 12) && (v >= 2) && (v < 6);
        if (e.v) begin
            e.x = 4'(h - 4);
            e.y = 3'(v - 2);
        end
        return e;
    endfunction

    task automatic adv(inout int h, inout int v);
        h++;
        if (h == 14) begin
            h = 0;
            v++;
            if (v == 7) v = 0;
        end
    endtask

    task automatic chk_req(input string tag, input ent_t e,
                           input logic rv, input logic [3:0] x,
                           input logic [2:0] y);
        chk({tag, "_req_valid"}, 32'(rv), 32'(e.v));
        chk({tag, "_curr_x"}, 32'(x), 32'(e.x));
        chk({tag, "_curr_y"}, 32'(y), 32'(e.y));
    endtask

    task automatic chk_out(input string tag, input ent_t o,
                           input logic de, input logic [3:0] r,
                           input logic [3:0] g, input logic [3:0] b,
                           input logic hs, input logic vs,
                           input logic ls, input logic fs,
                           input logic [3:0] er, input logic [3:0] eg,
                           input logic [3:0] eb);
        logic first;
        first = o.v && (o.x == 4'd0);
        chk({tag, "_de"}, 32'(de), 32'(o.v));
        chk({tag, "_pix_r"}, 32'(r), 32'(o.v ? er : 4'd0));
        chk({tag, "_pix_g"}, 32'(g), 32'(o.v ? eg : 4'd0));
        chk({tag, "_pix_b"}, 32'(b), 32'(o.v ? eb : 4'd0));
        chk({tag, "_hsync"}, 32'(hs), 32'(o.hs ? 1'b0 : 1'b1));
        chk({tag, "_vsync"}, 32'(vs), 32'(o.vs ? 1'b1 : 1'b0));
        chk({tag, "_line_start"}, 32'(ls), 32'(first));
        chk({tag, "_frame_start"}, 32'(fs),
            32'(first && (o.y == 3'd0)));
    endtask

    task automatic chk_idle(input string tag,
                            input logic [31:0] x, input logic [31:0] y,
                            input logic rv, input logic [11:0] rgb,
                            input logic de, input logic hs,
                            input logic vs, input logic ls,
                            input logic fs, input logic [7:0] fc);
        chk({tag, "_rst_xy"}, x | y, 32'd0);
        chk({tag, "_rst_req_valid"}, 32'(rv), 32'd0);
        chk({tag, "_rst_pix"}, 32'(rgb), 32'd0);
        chk({tag, "_rst_de"}, 32'(de), 32'd0);
        chk({tag, "_rst_hsync"}, 32'(hs), 32'd1);
        chk({tag, "_rst_vsync"}, 32'(vs), 32'd0);
        chk({tag, "_rst_pulses"}, 32'({ls, fs}), 32'd0);
        chk({tag, "_rst_frame_cnt"}, 32'(fc), 32'd0);
    endtask

    // ------------------------------------------------------------
    // Scoreboards and monitor state
    // ------------------------------------------------------------
    ent_t q2[$];
    ent_t q0[$];
    ent_t qt[$];
    int   s2_h = 0, s2_v = 0, s0_h = 0, s0_v = 0;
    int   tp_h = 0, tp_v = 0;
    int   n2 = 0, s2_last_fs = 0;
    int   s0_e = 0;
    bit   s0_arm = 0, s0_seen = 0;
    logic [3:0] h1x = '0, h2x = '0, h1y = '0, h2y = '0;

    bit   d0_arm = 0, d0_fs_seen = 0, d0_prev_hs = 1, d0_prev_de = 0;
    int   d0_e = 0, d0_hl = 0, d0_vh = 0, d0_dh = 0;
    int   d0_last_fall = 0, d0_lines = 0, d0_bad = 0;

    task automatic mon_d0();
        if (!(d0_rst_n && d0_arm)) return;
        d0_e++;
        if (d0_fs && !d0_fs_seen) begin
            chk("d0_rst_to_frame_start", 32'(d0_e), 32'd45700);
            chk("d0_frame_cnt", 32'(d0_fc), 32'd1);
            d0_fs_seen = 1;
        end
        if (!d0_hs) begin
            d0_hl++;
            if (d0_prev_hs) begin
                if (d0_last_fall > 0)
                    chk("d0_hsync_period",
                        32'(cyc - d0_last_fall), 32'd1680);
                d0_last_fall = cyc;
            end
        end else if (d0_hl > 0) begin
            chk("d0_hsync_width", 32'(d0_hl), 32'd136);
            d0_hl = 0;
        end
        if (d0_vs) begin
            d0_vh++;
        end else if (d0_vh > 0) begin
            chk("d0_vsync_width", 32'(d0_vh), 32'd5040);
            d0_vh = 0;
        end
        if (d0_de) begin
            d0_dh++;
        end else if (d0_dh > 0) begin
            chk("d0_de_width", 32'(d0_dh), 32'd1280);
            d0_dh = 0;
            d0_lines++;
        end
        if (d0_de ? ({d0_r, d0_g, d0_b} != 12'h5A3)
                  : ({d0_r, d0_g, d0_b} != 12'h000)) d0_bad++;
        if (d0_ls != (d0_de && !d0_prev_de)) d0_bad++;
        if (!d0_rv && (d0_x != '0 || d0_y != '0)) d0_bad++;
        d0_prev_hs = d0_hs;
        d0_prev_de = d0_de;
    endtask

    task automatic mon_s2();
        ent_t e, o;
        if (!s2_rst_n) return;
        e = model(s2_h, s2_v);
        adv(s2_h, s2_v);
        chk_req("s2", e, s2_rv, s2_x, s2_y);
        q2.push_back(e);
        if (q2.size() == 4) begin
            o = q2.pop_front();
            chk_out("s2", o, s2_de, s2_r, s2_g, s2_b, s2_hs, s2_vs,
                    s2_ls, s2_fs, o.x, {1'b0, o.y}, 4'hC);
        end
        if (s2_fs) begin
            n2++;
            chk("s2_frame_cnt", 32'(s2_fc), 32'(n2 % 256));
            if (n2 > 1)
                chk("s2_frame_period", 32'(cyc - s2_last_fs), 32'd98);
            s2_last_fs = cyc;
        end
    endtask

    task automatic mon_s0();
        ent_t e, o;
        if (!s0_rst_n) return;
        e = model(s0_h, s0_v);
        adv(s0_h, s0_v);
        chk_req("s0", e, s0_rv, s0_x, s0_y);
        q0.push_back(e);
        if (q0.size() == 2) begin
            o = q0.pop_front();
            chk_out("s0", o, s0_de, s0_r, s0_g, s0_b, s0_hs, s0_vs,
                    s0_ls, s0_fs, o.x, {1'b0, o.y}, 4'hC);
        end
        if (s0_arm) begin
            s0_e++;
            if (s0_fs) begin
                chk("s0_rst_to_frame_start", 32'(s0_e), 32'd34);
                s0_arm  = 0;
                s0_seen = 1;
            end
        end
    endtask

`ifdef VGA_TIMING_TEST_PATTERN_EN
    task automatic mon_tp();
        ent_t e, o;
        logic [3:0] cr, cg, cb;
        if (!tp_rst_n) return;
        e = model(tp_h, tp_v);
        adv(tp_h, tp_v);
        chk_req("tp", e, tp_rv, tp_x, tp_y);
        qt.push_back(e);
        if (qt.size() == 4) begin
            o  = qt.pop_front();
            cr = o.x[0] ? 4'hF : 4'h0;
            cg = o.x[1] ? 4'hF : 4'h0;
            cb = o.x[2] ? 4'hF : 4'h0;
            chk_out("tp", o, tp_de, tp_r, tp_g, tp_b, tp_hs, tp_vs,
                    tp_ls, tp_fs, cr, cg, cb);
        end
    endtask
`endif

    // One clock: sample on the falling edge, then drive draw inputs.
    task automatic tick();
        @(negedge clk);
        cyc++;
        mon_d0();
        mon_s2();
        mon_s0();
`ifdef VGA_TIMING_TEST_PATTERN_EN
        mon_tp();
`endif
        s2_dr = h2x;
        s2_dg = h2y;
        h2x   = h1x;
        h2y   = h1y;
        h1x   = s2_x;
        h1y   = {1'b0, s2_y};
        s0_dr = s0_x;
        s0_dg = {1'b0, s0_y};
    endtask

    initial begin
        d0_rst_n = 0;
        s2_rst_n = 0;
        s0_rst_n = 0;
`ifdef VGA_TIMING_TEST_PATTERN_EN
        tp_rst_n = 0;
`endif
        s2_dr = '0;
        s2_dg = '0;
        s0_dr = '0;
        s0_dg = '0;

        // Step 1: reset values with clocks running.
        #27;
        chk_idle("d0", 32'(d0_x), 32'(d0_y), d0_rv,
                 {d0_r, d0_g, d0_b}, d0_de, d0_hs, d0_vs,
                 d0_ls, d0_fs, d0_fc);
        chk_idle("s2", 32'(s2_x), 32'(s2_y), s2_rv,
                 {s2_r, s2_g, s2_b}, s2_de, s2_hs, s2_vs,
                 s2_ls, s2_fs, s2_fc);
        chk_idle("s0", 32'(s0_x), 32'(s0_y), s0_rv,
                 {s0_r, s0_g, s0_b}, s0_de, s0_hs, s0_vs,
                 s0_ls, s0_fs, s0_fc);

        // Step 2: release every instance between edges.
        @(negedge clk);
        d0_rst_n = 1;
        s2_rst_n = 1;
        s0_rst_n = 1;
`ifdef VGA_TIMING_TEST_PATTERN_EN
        tp_rst_n = 1;
`endif

        // Step 3: mid-line reset of the DRAW_LAT=0 small instance.
        repeat (200) tick();
        s0_rst_n = 0;
        #1;
        chk_idle("s0_mid", 32'(s0_x), 32'(s0_y), s0_rv,
                 {s0_r, s0_g, s0_b}, s0_de, s0_hs, s0_vs,
                 s0_ls, s0_fs, s0_fc);
        q0.delete();
        s0_h = 0;
        s0_v = 0;
        repeat (2) tick();
        s0_rst_n = 1;
        s0_e     = 0;
        s0_arm   = 1;

        // Step 4: mid-line reset of the default instance (hcnt ~510).
        repeat (308) tick();
        d0_rst_n = 0;
        #1;
        chk_idle("d0_mid", 32'(d0_x), 32'(d0_y), d0_rv,
                 {d0_r, d0_g, d0_b}, d0_de, d0_hs, d0_vs,
                 d0_ls, d0_fs, d0_fc);
        repeat (3) tick();
        d0_rst_n = 1;
        d0_e     = 0;
        d0_arm   = 1;

        // Step 5: free-run until 256+ small frames and the first
        // default-mode visible line have been observed.
        for (int i = 0; i < 60000; i++) begin
            if (d0_lines >= 1 && n2 >= 257 && s0_seen) break;
            tick();
        end

        // Step 6: completion and accumulated checks.
        chk("d0_frame_start_seen", 32'(d0_fs_seen), 32'd1);
        chk("d0_first_line_done", 32'(d0_lines >= 1), 32'd1);
        chk("d0_pixel_errors", 32'(d0_bad), 32'd0);
        chk("s2_frames_256", 32'(n2 >= 257), 32'd1);
        chk("s0_frame_start_seen", 32'(s0_seen), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
